// File: rtl/fifo_stream_reader_pkg.sv
// Shared helpers for the FIFO stream reader: log2 sizing and counter-width derivation.
package fifo_stream_reader_pkg;

  // Ceiling log2, matching the helper used by the FIFO this block drains.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Width able to hold 0..buf_depth inclusive (level and in-flight counters).
  function automatic int cnt_width(input int buf_depth);
    return clog2(buf_depth + 1);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_buffer.sv
// Circular word buffer: push at wr_ptr, pop at rd_ptr, head word always visible.
// Callers guarantee no push when full and no pop when empty.
module stream_buffer
  import fifo_stream_reader_pkg::*;
#(
  parameter  int DATA_WIDTH = 1,
  parameter  int BUF_DEPTH  = 4,
  localparam int CNT_WIDTH  = cnt_width(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CNT_WIDTH-1:0]  count
);

  localparam int PTR_WIDTH = clog2(BUF_DEPTH);
  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(BUF_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  // Explicit compare so non-power-of-two depths wrap at BUF_DEPTH-1.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_WIDTH'(1);
  endfunction

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    // NOTE: every signal gets a default before any branch, otherwise an
    // incomplete if/case infers a latch.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the storage is cleared too, so the head word reads as zero
      // straight out of reset instead of stale contents; sequential state is
      // always written with <= so every flop samples pre-edge values.
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO pop port into a valid/ready stream. Pops are credit-limited so
// every granted response has a guaranteed buffer slot, even under back-pressure.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter  int DATA_WIDTH = 1,
  parameter  int BUF_DEPTH  = 4,
  localparam int CNT_WIDTH  = cnt_width(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_valid,
  input  logic                  fifo_empty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  level,
  output logic                  protocol_err
);

  // One extra bit so count + inflight can never wrap.
  localparam logic [CNT_WIDTH:0] CREDIT_LIMIT = (CNT_WIDTH + 1)'(BUF_DEPTH);

  logic [CNT_WIDTH-1:0] inflight_q, inflight_d;
  logic                 protocol_err_q, protocol_err_d;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH:0]   credit_used;
  logic                 has_outstanding;
  logic                 push;
  logic                 pop;
  logic                 spurious_rsp;

  assign credit_used     = {1'b0, count} + {1'b0, inflight_q};
  assign has_outstanding = (inflight_q != '0);

  // A response only counts when a pop is outstanding; anything else is a protocol error.
  assign push         = fifo_rd_valid & has_outstanding;
  assign spurious_rsp = fifo_rd_valid & ~has_outstanding;

  // Issue only when buffered plus in-flight words leave room for the response.
  assign fifo_rd_en = enable & ~fifo_empty & ~reset & (credit_used < CREDIT_LIMIT);

  assign m_valid = (count != '0);
  assign pop     = m_valid & m_ready;

  stream_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buffer (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .head_data (m_data),
    .count     (count)
  );

  // Credit counter and sticky error flag next-state.
  always_comb begin
    inflight_d     = inflight_q;
    protocol_err_d = protocol_err_q | spurious_rsp;

    case ({fifo_rd_en, push})
      2'b10:   inflight_d = inflight_q + CNT_WIDTH'(1);
      2'b01:   inflight_d = inflight_q - CNT_WIDTH'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Credit and error registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q     <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      inflight_q     <= inflight_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign level        = count;
  assign protocol_err = protocol_err_q;

endmodule
